// File: rtl/duck_wave_ctl.sv
// duck_wave_ctl: spawns, moves and hit-tests up to NUM_DUCKS ducks; keeps score/escapes and ends the round.
// Latency: left_mouse press sampled at edge N -> click registered at N+1 -> hit_pulse/score/FALL after N+2.
// Backpressure: none; game_enable=0 freezes everything, game_finished=1 freezes tick/spawn/click logic.
// Ports: clk, rst (sync, active-low), game_enable, lfsr_number, left_mouse, mouse_xpos/ypos in;
//        duck_xpos/ypos (slot i at [12i+11:12i]), duck_active, duck_falling, hit_pulse, score, misses,
//        game_finished out.
module duck_wave_ctl #(
    parameter int NUM_DUCKS       = 4,
    parameter int LFSR_WIDTH      = 10,
    parameter int DUCK_WIDTH      = 64,
    parameter int DUCK_HEIGHT     = 48,
    parameter int SCREEN_W        = 1024,
    parameter int SCREEN_H        = 768,
    parameter int MOVE_DIV        = 650000,
    parameter int SPAWN_GAP       = 50,
    parameter int DUCKS_PER_ROUND = 10,
    parameter int MAX_MISSES      = 3,
    parameter int SCORE_WIDTH     = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    game_enable,
    input  logic [LFSR_WIDTH-1:0]   lfsr_number,
    input  logic                    left_mouse,
    input  logic [11:0]             mouse_xpos,
    input  logic [11:0]             mouse_ypos,
    output logic [NUM_DUCKS*12-1:0] duck_xpos,
    output logic [NUM_DUCKS*12-1:0] duck_ypos,
    output logic [NUM_DUCKS-1:0]    duck_active,
    output logic [NUM_DUCKS-1:0]    duck_falling,
    output logic                    hit_pulse,
    output logic [SCORE_WIDTH-1:0]  score,
    output logic [3:0]              misses,
    output logic                    game_finished
);
    typedef enum logic [1:0] {S_IDLE = 2'd0, S_FLY = 2'd1, S_FALL = 2'd2} slot_state_t;

    localparam logic [11:0] X_MAX = 12'(SCREEN_W - DUCK_WIDTH);
    localparam logic [11:0] Y_BOT = 12'(SCREEN_H - DUCK_HEIGHT);
    localparam int DIV_W = $clog2(MOVE_DIV + 2);
    localparam int GAP_W = $clog2(SPAWN_GAP + 2);
    localparam int SPN_W = $clog2(DUCKS_PER_ROUND + 2);

    slot_state_t              r_state [NUM_DUCKS];
    logic [11:0]              r_x     [NUM_DUCKS];
    logic [11:0]              r_y     [NUM_DUCKS];
    logic [NUM_DUCKS-1:0]     r_dir;
    logic [DIV_W-1:0]         r_div;
    logic [GAP_W-1:0]         r_gap;
    logic [SPN_W-1:0]         r_spawned;
    logic [SCORE_WIDTH-1:0]   r_score;
    logic [3:0]               r_misses;
    logic                     r_finished;
    logic                     r_hit_pulse;
    logic                     r_en_prev;
    logic                     r_lm_cur;
    logic                     r_lm_prev;
    logic                     r_click;

    slot_state_t              w_state_nxt [NUM_DUCKS];
    logic [11:0]              w_x_nxt     [NUM_DUCKS];
    logic [11:0]              w_y_nxt     [NUM_DUCKS];
    logic [NUM_DUCKS-1:0]     w_dir_nxt;
    logic [NUM_DUCKS-1:0]     w_idle;
    logic [NUM_DUCKS-1:0]     w_hit;
    logic [NUM_DUCKS-1:0]     w_hit_sel;
    logic [NUM_DUCKS-1:0]     w_spawn_sel;
    logic [NUM_DUCKS-1:0]     w_esc;
    logic [3:0]               w_esc_cnt;
    logic [GAP_W-1:0]         w_gap_inc;
    logic [11:0]              w_lfsr12;
    logic [11:0]              w_spawn_x;
    logic                     w_en_rise;
    logic                     w_run;
    logic                     w_tick;
    logic                     w_click;
    logic                     w_spawn;

    // The enable edge clears the round; it takes priority over any gameplay event in that cycle.
    assign w_en_rise = game_enable & ~r_en_prev;
    assign w_run     = game_enable & ~r_finished & ~w_en_rise;
    assign w_tick    = w_run && (r_div == DIV_W'(MOVE_DIV - 1));
    assign w_click   = w_run & r_click;
    assign w_gap_inc = (r_gap >= GAP_W'(SPAWN_GAP)) ? GAP_W'(SPAWN_GAP) : r_gap + 1'b1;
    assign w_lfsr12  = 12'(lfsr_number);
    assign w_spawn_x = (w_lfsr12 < X_MAX) ? w_lfsr12 : w_lfsr12 - X_MAX;
    assign w_spawn   = w_tick && (w_gap_inc == GAP_W'(SPAWN_GAP)) && (|w_idle)
                       && (r_spawned < SPN_W'(DUCKS_PER_ROUND));

    always_comb begin
        w_idle = '0;
        w_hit  = '0;
        for (int i = 0; i < NUM_DUCKS; i++) begin
            w_idle[i] = (r_state[i] == S_IDLE);
            w_hit[i]  = (r_state[i] == S_FLY)
                     && (mouse_xpos >= r_x[i])
                     && ({1'b0, mouse_xpos} < ({1'b0, r_x[i]} + 13'(DUCK_WIDTH)))
                     && (mouse_ypos >= r_y[i])
                     && ({1'b0, mouse_ypos} < ({1'b0, r_y[i]} + 13'(DUCK_HEIGHT)));
        end
    end

    // Lowest-index winner for both the hit and the spawn slot.
    always_comb begin
        logic v_hit_found;
        logic v_idle_found;
        v_hit_found  = 1'b0;
        v_idle_found = 1'b0;
        w_hit_sel    = '0;
        w_spawn_sel  = '0;
        for (int i = 0; i < NUM_DUCKS; i++) begin
            if (w_click && w_hit[i] && !v_hit_found) begin
                w_hit_sel[i] = 1'b1;
                v_hit_found  = 1'b1;
            end
            if (w_spawn && w_idle[i] && !v_idle_found) begin
                w_spawn_sel[i] = 1'b1;
                v_idle_found   = 1'b1;
            end
        end
    end

    always_comb begin
        w_esc     = '0;
        w_dir_nxt = r_dir;
        for (int i = 0; i < NUM_DUCKS; i++) begin
            w_state_nxt[i] = r_state[i];
            w_x_nxt[i]     = r_x[i];
            w_y_nxt[i]     = r_y[i];
            case (r_state[i])
                S_IDLE: begin
                    if (w_spawn_sel[i]) begin
                        w_state_nxt[i] = S_FLY;
                        w_x_nxt[i]     = w_spawn_x;
                        w_y_nxt[i]     = Y_BOT;
                        w_dir_nxt[i]   = lfsr_number[0];
                    end
                end
                S_FLY: begin
                    // A hit beats both movement and escape on the same cycle.
                    if (w_hit_sel[i]) begin
                        w_state_nxt[i] = S_FALL;
                    end else if (w_tick) begin
                        if (r_y[i] == 12'd0) begin
                            w_state_nxt[i] = S_IDLE;
                            w_esc[i]       = 1'b1;
                        end else begin
                            w_y_nxt[i] = r_y[i] - 12'd1;
                            // At an edge the duck turns around and spends this tick in place.
                            if (r_dir[i] && (r_x[i] >= X_MAX)) begin
                                w_dir_nxt[i] = 1'b0;
                            end else if (!r_dir[i] && (r_x[i] == 12'd0)) begin
                                w_dir_nxt[i] = 1'b1;
                            end else if (r_dir[i]) begin
                                w_x_nxt[i] = r_x[i] + 12'd1;
                            end else begin
                                w_x_nxt[i] = r_x[i] - 12'd1;
                            end
                        end
                    end
                end
                S_FALL: begin
                    if (w_tick) begin
                        if (({1'b0, r_y[i]} + 13'd2) >= {1'b0, Y_BOT}) begin
                            w_y_nxt[i]     = Y_BOT;
                            w_state_nxt[i] = S_IDLE;
                        end else begin
                            w_y_nxt[i] = r_y[i] + 12'd2;
                        end
                    end
                end
                default: w_state_nxt[i] = S_IDLE;
            endcase
        end
    end

    always_comb begin
        w_esc_cnt = 4'd0;
        for (int i = 0; i < NUM_DUCKS; i++) begin
            w_esc_cnt = w_esc_cnt + 4'(w_esc[i]);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < NUM_DUCKS; i++) begin
                r_state[i] <= S_IDLE;
                r_x[i]     <= '0;
                r_y[i]     <= '0;
            end
            r_dir       <= '0;
            r_div       <= '0;
            r_gap       <= '0;
            r_spawned   <= '0;
            r_score     <= '0;
            r_misses    <= '0;
            r_finished  <= 1'b0;
            r_hit_pulse <= 1'b0;
            r_en_prev   <= 1'b0;
            r_lm_cur    <= 1'b0;
            r_lm_prev   <= 1'b0;
            r_click     <= 1'b0;
        end else begin
            r_en_prev   <= game_enable;
            r_lm_cur    <= left_mouse;
            r_lm_prev   <= r_lm_cur;
            r_click     <= r_lm_cur & ~r_lm_prev;
            r_hit_pulse <= 1'b0;
            if (w_en_rise) begin
                for (int i = 0; i < NUM_DUCKS; i++) begin
                    r_state[i] <= S_IDLE;
                    r_x[i]     <= '0;
                    r_y[i]     <= '0;
                end
                r_dir      <= '0;
                r_div      <= '0;
                r_gap      <= '0;
                r_spawned  <= '0;
                r_score    <= '0;
                r_misses   <= '0;
                r_finished <= 1'b0;
            end else if (w_run) begin
                for (int i = 0; i < NUM_DUCKS; i++) begin
                    r_state[i] <= w_state_nxt[i];
                    r_x[i]     <= w_x_nxt[i];
                    r_y[i]     <= w_y_nxt[i];
                end
                r_dir <= w_dir_nxt;
                r_div <= w_tick ? '0 : r_div + 1'b1;
                if (w_tick) begin
                    r_gap <= w_spawn ? '0 : w_gap_inc;
                end
                if (w_spawn) begin
                    r_spawned <= r_spawned + 1'b1;
                end
                if (|w_hit_sel) begin
                    r_hit_pulse <= 1'b1;
                    if (r_score != '1) begin
                        r_score <= r_score + 1'b1;
                    end
                end
                r_misses <= r_misses + w_esc_cnt;
                // Built from registered state, so it lands one cycle after the triggering update.
                r_finished <= (r_misses >= 4'(MAX_MISSES))
                           || ((r_spawned == SPN_W'(DUCKS_PER_ROUND)) && (&w_idle));
            end
        end
    end

    always_comb begin
        duck_xpos    = '0;
        duck_ypos    = '0;
        duck_active  = '0;
        duck_falling = '0;
        for (int i = 0; i < NUM_DUCKS; i++) begin
            duck_xpos[12*i +: 12] = r_x[i];
            duck_ypos[12*i +: 12] = r_y[i];
            duck_active[i]        = (r_state[i] != S_IDLE);
            duck_falling[i]       = (r_state[i] == S_FALL);
        end
    end

    assign hit_pulse     = r_hit_pulse;
    assign score         = r_score;
    assign misses        = r_misses;
    assign game_finished = r_finished;
endmodule

// File: tb/tb_duck_wave_ctl.sv
module tb_duck_wave_ctl;
    logic        clk = 1'b0;
    logic        rst;
    logic        game_enable;
    logic [9:0]  lfsr_number;
    logic        left_mouse;
    logic [11:0] mouse_xpos;
    logic [11:0] mouse_ypos;
    logic [23:0] duck_xpos;
    logic [23:0] duck_ypos;
    logic [1:0]  duck_active;
    logic [1:0]  duck_falling;
    logic        hit_pulse;
    logic [7:0]  score;
    logic [3:0]  misses;
    logic        game_finished;

    int total = 0;
    int bad   = 0;

    duck_wave_ctl #(
        .NUM_DUCKS(2), .MOVE_DIV(4), .SPAWN_GAP(2), .DUCKS_PER_ROUND(3), .MAX_MISSES(2)
    ) dut (
        .clk(clk), .rst(rst), .game_enable(game_enable), .lfsr_number(lfsr_number),
        .left_mouse(left_mouse), .mouse_xpos(mouse_xpos), .mouse_ypos(mouse_ypos),
        .duck_xpos(duck_xpos), .duck_ypos(duck_ypos), .duck_active(duck_active),
        .duck_falling(duck_falling), .hit_pulse(hit_pulse), .score(score),
        .misses(misses), .game_finished(game_finished)
    );

    always #5 clk = ~clk;

    // Advance n rising edges, then settle 1 time unit so outputs are sampled away from the edge.
    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Leaves the bench just after edge E0, the edge that sees game_enable rise.
    task automatic enable_round();
        left_mouse  = 1'b0;
        game_enable = 1'b0;
        step(2);
        game_enable = 1'b1;
        step(1);
    endtask

    task automatic press(input logic [11:0] x, input logic [11:0] y);
        mouse_xpos = x;
        mouse_ypos = y;
        left_mouse = 1'b1;
    endtask

    task automatic test_reset();
        rst = 1'b0; game_enable = 1'b0; left_mouse = 1'b0;
        lfsr_number = 10'd0; mouse_xpos = 12'd0; mouse_ypos = 12'd0;
        step(2);
        total++; if (duck_active !== 2'b00 || duck_falling !== 2'b00) begin bad++;
            $display("FAIL reset_slots got active=%b falling=%b want 00/00", duck_active, duck_falling); end
        total++; if (duck_xpos !== 24'd0 || duck_ypos !== 24'd0) begin bad++;
            $display("FAIL reset_pos got x=%h y=%h want 0", duck_xpos, duck_ypos); end
        total++; if ({hit_pulse, game_finished, misses, score} !== 14'd0) begin bad++;
            $display("FAIL reset_counters got hit=%b fin=%b misses=%0d score=%0d want 0", hit_pulse, game_finished, misses, score); end
        rst = 1'b1;
    endtask

    task automatic test_spawn();
        lfsr_number = 10'd1000;
        enable_round();
        step(7);
        total++; if (duck_active !== 2'b00) begin bad++;
            $display("FAIL spawn_early got active=%b want 00", duck_active); end
        step(1);
        total++; if (duck_active !== 2'b01) begin bad++;
            $display("FAIL spawn_active got %b want 01", duck_active); end
        total++; if (duck_xpos[11:0] !== 12'd40 || duck_ypos[11:0] !== 12'd720) begin bad++;
            $display("FAIL spawn_pos got (%0d,%0d) want (40,720)", duck_xpos[11:0], duck_ypos[11:0]); end
        lfsr_number = 10'h3FF;
        step(8);
        total++; if (duck_active !== 2'b11) begin bad++;
            $display("FAIL spawn2_active got %b want 11", duck_active); end
        total++; if (duck_xpos !== {12'd63, 12'd38} || duck_ypos !== {12'd720, 12'd718}) begin bad++;
            $display("FAIL spawn2_pos got x=%h y=%h want x=03f026 y=2d02ce", duck_xpos, duck_ypos); end
    endtask

    task automatic test_hit();
        lfsr_number = 10'd520;
        enable_round();
        step(1687);
        press(12'd100, 12'd300);
        step(1);
        total++; if (duck_xpos !== {12'd102, 12'd100} || duck_ypos !== {12'd302, 12'd300}) begin bad++;
            $display("FAIL hit_prepos got x=%h y=%h want x=066064 y=12e12c", duck_xpos, duck_ypos); end
        step(1);
        total++; if (hit_pulse !== 1'b0) begin bad++;
            $display("FAIL hit_early got %b want 0", hit_pulse); end
        step(1);
        total++; if (hit_pulse !== 1'b1 || score !== 8'd1 || duck_falling !== 2'b01) begin bad++;
            $display("FAIL hit_score got hit=%b score=%0d falling=%b want 1/1/01", hit_pulse, score, duck_falling); end
        step(1);
        total++; if (hit_pulse !== 1'b0) begin bad++;
            $display("FAIL hit_oneshot got %b want 0", hit_pulse); end
        left_mouse = 1'b0;
        step(2);
        press(12'd164, 12'd300);
        step(3);
        total++; if (hit_pulse !== 1'b0 || score !== 8'd1 || duck_falling !== 2'b01) begin bad++;
            $display("FAIL miss_click got hit=%b score=%0d falling=%b want 0/1/01", hit_pulse, score, duck_falling); end
        left_mouse = 1'b0;
    endtask

    task automatic test_overlap();
        lfsr_number = 10'd720;
        enable_round();
        step(8);
        lfsr_number = 10'd718;
        step(2079);
        press(12'd210, 12'd210);
        step(1);
        total++; if (duck_xpos !== {12'd200, 12'd200} || duck_ypos !== {12'd202, 12'd200}) begin bad++;
            $display("FAIL overlap_pos got x=%h y=%h want x=0c80c8 y=0ca0c8", duck_xpos, duck_ypos); end
        step(2);
        total++; if (duck_falling !== 2'b01 || score !== 8'd1 || duck_active !== 2'b11) begin bad++;
            $display("FAIL overlap_hit got falling=%b score=%0d active=%b want 01/1/11", duck_falling, score, duck_active); end
        left_mouse = 1'b0;
    endtask

    task automatic test_escape();
        lfsr_number = 10'd1000;
        enable_round();
        step(2891);
        total++; if (misses !== 4'd0) begin bad++;
            $display("FAIL esc_before got misses=%0d want 0", misses); end
        step(1);
        total++; if (misses !== 4'd1 || duck_active !== 2'b10) begin bad++;
            $display("FAIL esc_first got misses=%0d active=%b want 1/10", misses, duck_active); end
        step(4);
        total++; if (duck_active !== 2'b11) begin bad++;
            $display("FAIL esc_respawn got active=%b want 11", duck_active); end
        step(4);
        total++; if (misses !== 4'd2 || game_finished !== 1'b0) begin bad++;
            $display("FAIL esc_second got misses=%0d fin=%b want 2/0", misses, game_finished); end
        step(1);
        total++; if (game_finished !== 1'b1) begin bad++;
            $display("FAIL esc_finished got %b want 1", game_finished); end
        press(12'd50, 12'd730);
        step(3);
        total++; if (hit_pulse !== 1'b0 || score !== 8'd0 || duck_falling !== 2'b00) begin bad++;
            $display("FAIL frozen_click got hit=%b score=%0d falling=%b want 0/0/00", hit_pulse, score, duck_falling); end
        total++; if (duck_ypos[11:0] !== 12'd719) begin bad++;
            $display("FAIL frozen_pos got y=%0d want 719", duck_ypos[11:0]); end
        left_mouse = 1'b0;
    endtask

    task automatic test_bounce();
        lfsr_number = 10'd959;
        enable_round();
        step(8);
        lfsr_number = 10'd0;
        step(4);
        total++; if (duck_xpos[11:0] !== 12'd960) begin bad++;
            $display("FAIL bounce_reach got x=%0d want 960", duck_xpos[11:0]); end
        step(4);
        total++; if (duck_xpos !== {12'd0, 12'd960}) begin bad++;
            $display("FAIL bounce_hold got x=%h want 0003c0", duck_xpos); end
        step(4);
        total++; if (duck_xpos !== {12'd0, 12'd959}) begin bad++;
            $display("FAIL bounce_turn got x=%h want 0003bf", duck_xpos); end
        step(4);
        total++; if (duck_xpos !== {12'd1, 12'd958}) begin bad++;
            $display("FAIL bounce_left got x=%h want 0013be", duck_xpos); end
        rst = 1'b0;
        step(1);
        total++; if (duck_active !== 2'b00 || duck_xpos !== 24'd0 || duck_ypos !== 24'd0) begin bad++;
            $display("FAIL abort_reset got active=%b x=%h y=%h want 0", duck_active, duck_xpos, duck_ypos); end
        rst = 1'b1;
    endtask

    task automatic test_round_end();
        lfsr_number = 10'd1000;
        enable_round();
        step(8);
        press(12'd40, 12'd720);
        step(2);
        total++; if (hit_pulse !== 1'b0) begin bad++;
            $display("FAIL re_hit_early got %b want 0", hit_pulse); end
        step(1);
        total++; if (hit_pulse !== 1'b1 || score !== 8'd1 || duck_falling !== 2'b01) begin bad++;
            $display("FAIL re_hit1 got hit=%b score=%0d falling=%b want 1/1/01", hit_pulse, score, duck_falling); end
        left_mouse = 1'b0;
        step(1);
        total++; if (duck_active !== 2'b00) begin bad++;
            $display("FAIL re_land got active=%b want 00", duck_active); end
        step(4);
        total++; if (duck_active !== 2'b01) begin bad++;
            $display("FAIL re_spawn2 got active=%b want 01", duck_active); end
        left_mouse = 1'b1;
        step(3);
        total++; if (score !== 8'd2) begin bad++;
            $display("FAIL re_hit2 got score=%0d want 2", score); end
        left_mouse = 1'b0;
        step(5);
        total++; if (duck_active !== 2'b01) begin bad++;
            $display("FAIL re_spawn3 got active=%b want 01", duck_active); end
        left_mouse = 1'b1;
        step(3);
        total++; if (score !== 8'd3 || hit_pulse !== 1'b1) begin bad++;
            $display("FAIL re_hit3 got score=%0d hit=%b want 3/1", score, hit_pulse); end
        left_mouse = 1'b0;
        step(1);
        total++; if (game_finished !== 1'b0 || duck_active !== 2'b00) begin bad++;
            $display("FAIL re_last_idle got fin=%b active=%b want 0/00", game_finished, duck_active); end
        step(1);
        total++; if (game_finished !== 1'b1) begin bad++;
            $display("FAIL re_finished got %b want 1", game_finished); end
        game_enable = 1'b0;
        step(3);
        total++; if (score !== 8'd3 || game_finished !== 1'b1) begin bad++;
            $display("FAIL disable_hold got score=%0d fin=%b want 3/1", score, game_finished); end
        game_enable = 1'b1;
        step(1);
        total++; if (score !== 8'd0 || misses !== 4'd0 || game_finished !== 1'b0) begin bad++;
            $display("FAIL reenable_clear got score=%0d misses=%0d fin=%b want 0/0/0", score, misses, game_finished); end
    endtask

    initial begin
        test_reset();
        test_spawn();
        test_hit();
        test_overlap();
        test_escape();
        test_bounce();
        test_round_end();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/duck_wave_ctl.md
# duck_wave_ctl

Parametrised multi-duck gameplay controller. It replaces the single-duck position generator and closes the open `game_finished` loop in the game top. It spawns up to NUM_DUCKS ducks from the LFSR, moves them on a divided tick, and hit-tests left clicks against every flying duck. It also counts score and escapes, and asserts `game_finished` when the round ends. Its outputs feed the per-duck draw stages and `game_control_fsm`.

## Interface
- NUM_DUCKS, 4: number of duck slots (1..8)
- LFSR_WIDTH, 10: width of `lfsr_number`
- DUCK_WIDTH, 64: duck sprite width in pixels
- DUCK_HEIGHT, 48: duck sprite height in pixels
- SCREEN_W, 1024: visible width
- SCREEN_H, 768: visible height
- MOVE_DIV, 650000: clk cycles per movement tick
- SPAWN_GAP, 50: movement ticks between spawns
- DUCKS_PER_ROUND, 10: ducks spawned per round
- MAX_MISSES, 3: escapes that end the round
- SCORE_WIDTH, 8: score counter width
- clk  in  1  system clock (65 MHz pixel domain)
- rst  in  1  one clock; reset is synchronous and active-low
- game_enable  in  1  gameplay active (from `game_control_fsm`)
- lfsr_number  in  LFSR_WIDTH  pseudo-random value, refreshed every cycle
- left_mouse  in  1  left button level
- mouse_xpos, mouse_ypos  in  12 each  cursor position
- duck_xpos, duck_ypos  out  NUM_DUCKS*12 each  packed slot positions; slot i is bits [12i+11:12i]
- duck_active  out  NUM_DUCKS  slot i is drawn when bit i = 1
- duck_falling  out  NUM_DUCKS  slot i is in FALL
- hit_pulse  out  1  one-cycle pulse per scored hit
- score  out  SCORE_WIDTH  hit count, saturating at all-ones
- misses  out  4  escape count
- game_finished  out  1  round over, held

## Operation
- Per-slot FSM states: IDLE, FLY, FALL. `duck_active` = (state != IDLE).
- Tick: a divider counts 0..MOVE_DIV-1 while `game_enable`=1 and `game_finished`=0. `tick` = 1 on the wrap.
- Spawn timer:
  - Counts ticks.
  - When the count reaches SPAWN_GAP, at least one slot is IDLE, and `spawned` < DUCKS_PER_ROUND:
    - The lowest-index IDLE slot enters FLY.
    - `spawned` increments.
    - The spawn timer clears.
  - Otherwise the spawn timer saturates at SPAWN_GAP.
- Spawn position:
  - Let r = `lfsr_number` zero-extended to 12 bits.
  - x = r if r < SCREEN_W-DUCK_WIDTH, else r-(SCREEN_W-DUCK_WIDTH).
  - y = SCREEN_H-DUCK_HEIGHT.
  - Per-slot dir bit = `lfsr_number[0]` (1 = right).
- FLY on tick:
  - y decrements by 1.
  - x moves by ±1.
  - At x=0 moving left, or x=SCREEN_W-DUCK_WIDTH moving right, dir flips and x holds that tick.
  - If y=0 before the decrement: slot goes to IDLE and `misses` increments.
- FALL on tick:
  - y increments by 2, clamped at SCREEN_H-DUCK_HEIGHT.
  - When y reaches the clamp, slot goes to IDLE.
  - x holds.
- Click detection: `left_mouse` is registered once. click = cur & ~prev. Only one detector runs; there is no double-synchronising.
- Hit test, on the click cycle:
  - A slot hits when it is in FLY and x ≤ mouse_x < x+DUCK_WIDTH and y ≤ mouse_y < y+DUCK_HEIGHT.
  - Only the lowest-index hit slot scores; it goes to FALL.
  - `score` increments (saturating) and `hit_pulse` fires.
  - A click with no hit has no effect.
- Round end: `game_finished` is set when either condition holds:
  - `misses` reaches MAX_MISSES, or
  - `spawned` = DUCKS_PER_ROUND and all slots are IDLE.
  - Once set, `game_finished` holds and freezes the tick, spawn, and click logic.
- `game_enable`=0: all state freezes and the outputs hold, so the end screen can read `score`.
- Rising edge of `game_enable` (registered): clears slots to IDLE, positions to 0, and clears `score`, `misses`, `spawned`, timers, and `game_finished`.

## Timing
- Reset (rst=0 at a clk edge): all outputs are 0; all slots IDLE; all counters 0.
- Click latency: `left_mouse` rising edge sampled at edge N gives click at N+1. At edge N+2:
  - `hit_pulse`=1 for one cycle;
  - `score` is updated;
  - the slot is in FALL.
- The hit test uses positions as registered at the click cycle.
- Click and tick in the same cycle: the hit wins. The hit slot enters FALL and does not move that tick. Other slots move normally.
- Hit and escape on the same slot in the same cycle: the hit wins. `misses` is unchanged.
- Spawn and escape in the same cycle: the spawn uses the lowest IDLE slot as seen before the update. The escaping slot is not reused until the next tick.
- `game_finished` is registered: it asserts one cycle after the last slot becomes IDLE, or one cycle after `misses` = MAX_MISSES.
- A rising edge of `game_enable` and a click in the same cycle: the clear wins and the click is ignored.
- rst=0 mid-round aborts immediately to the reset state.

## Test plan
Bench parameters: MOVE_DIV=4, SPAWN_GAP=2, NUM_DUCKS=2, DUCKS_PER_ROUND=3, MAX_MISSES=2.

- Reset then enable, with `lfsr_number`=1000:
  - First spawn after 8 cycles gives slot0 x=1000-960=40, y=720, `duck_active`=01.
  - With `lfsr_number`=0x3FF (1023): x=63.
- Slot0 at (100,300), click at (100,300): `hit_pulse` fires 2 cycles after the press; `score`=1; `duck_falling`=01. A click at (164,300) gives no hit.
- Both slots overlapping at (200,200), click at (210,210): only slot0 falls; `score`=1.
- Slot in FLY at y=0: on the next tick the slot goes IDLE and `misses`=1. After a second escape, `misses`=2 and `game_finished`=1; further clicks leave `score` unchanged.
- x bounce: a slot at x=960 moving right gets x=960 and dir=left on the tick, then x=959 on the following tick.
- With `game_finished`=1 and `score`=3: dropping `game_enable` holds `score`=3. Re-asserting it clears `score`, `misses`, and `game_finished` to 0 one cycle after the edge.
